// File: rtl/ptp_ts_pkg.sv
// ptp_ts_pkg: shared widths, field offsets and word slicing for the PTP timestamp unpacker
package ptp_ts_pkg;
    localparam int PTP_TS_W      = 96;
    localparam int PTP_WORD_W    = 32;
    localparam int PTP_WORDS     = 3;
    localparam int PTP_SEC_LSB   = 48;
    localparam int PTP_SEC_W     = 48;
    localparam int PTP_NS_LSB    = 16;
    localparam int PTP_NS_W      = 32;
    localparam int PTP_FRAC_LSB  = 0;
    localparam int PTP_FRAC_W    = 16;

    typedef logic [1:0] word_idx_t;

    // Word 0 is the most significant slice.
    function automatic logic [PTP_WORD_W-1:0] ts_word(input logic [PTP_TS_W-1:0] ts, input word_idx_t idx);
        return ts[PTP_TS_W - 1 - int'(idx) * PTP_WORD_W -: PTP_WORD_W];
    endfunction
endpackage

// File: rtl/ptp_ts_unpacker_if.sv
// ptp_ts_unpacker_if: timestamp input stream and 32-bit serialised output stream
interface ptp_ts_unpacker_if;
    import ptp_ts_pkg::*;
    logic [PTP_TS_W-1:0]   s_axis_ts_96;
    logic                  s_axis_ts_valid;
    logic                  s_axis_ts_ready;
    logic [PTP_WORD_W-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output s_axis_ts_96, s_axis_ts_valid, m_axis_tready,
        input  s_axis_ts_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
    modport slave (
        input  s_axis_ts_96, s_axis_ts_valid, m_axis_tready,
        output s_axis_ts_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/ptp_ts_fifo.sv
// ptp_ts_fifo: synchronous timestamp FIFO with wrap-bit pointers, full/empty and fill level
module ptp_ts_fifo
    import ptp_ts_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [PTP_TS_W-1:0]     din,
    output logic [PTP_TS_W-1:0]     dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);

    logic [PTP_TS_W-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/ptp_ts_unpacker.sv
// ptp_ts_unpacker: buffers 96-bit PTP timestamps and emits each as three 32-bit stream words
module ptp_ts_unpacker
    import ptp_ts_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter bit DROP_WHEN_FULL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    ptp_ts_unpacker_if.slave       bus,
    input  logic                   overflow_clear,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [15:0]            overflow_count
);
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;
    logic                hs;
    logic [PTP_TS_W-1:0] head;
    word_idx_t           word_idx;

    // Ready depends only on registered fullness, never on downstream tready.
    assign bus.s_axis_ts_ready = !rst && (DROP_WHEN_FULL || !full);
    assign bus.m_axis_tvalid   = !empty;
    assign bus.m_axis_tdata    = ts_word(head, word_idx);
    assign bus.m_axis_tlast    = word_idx == 2'(PTP_WORDS - 1);

    assign hs   = bus.m_axis_tvalid && bus.m_axis_tready;
    assign pop  = hs && bus.m_axis_tlast;
    assign push = bus.s_axis_ts_valid && bus.s_axis_ts_ready && !full;
    assign drop = DROP_WHEN_FULL && bus.s_axis_ts_valid && full;

    ptp_ts_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.s_axis_ts_96),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fill_level)
    );

    always_ff @(posedge clk) begin
        if (rst)
            word_idx <= '0;
        else if (hs)
            word_idx <= pop ? '0 : word_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            overflow_count <= '0;
        else if (drop)
            overflow_count <= overflow_clear ? 16'd1 : (&overflow_count) ? overflow_count : overflow_count + 16'd1;
        else if (overflow_clear)
            overflow_count <= '0;
    end
endmodule
